// File: rtl/femto_uart_pkg.sv
// rtl/femto_uart_pkg.sv - shared register map, bit indices and FSM encodings for wb_uart8
package femto_uart_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_ID     = 2'd3;

    localparam logic [7:0] ID_VALUE = 8'h5A;

    localparam int ST_TX_FULL    = 0;
    localparam int ST_TX_EMPTY   = 1;
    localparam int ST_RX_VALID   = 2;
    localparam int ST_RX_OVERRUN = 3;
    localparam int ST_TX_BUSY    = 4;
    localparam int ST_FRAME_ERR  = 5;

    localparam int CTRL_RX_IRQ_EN = 0;
    localparam int CTRL_TX_IRQ_EN = 1;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/wb_uart8_if.sv
// rtl/wb_uart8_if.sv - byte-wide Wishbone classic bus bundle for wb_uart8
interface wb_uart8_if;
    logic       wb_cyc_i;
    logic       wb_stb_i;
    logic       wb_we_i;
    logic [7:0] wb_adr_i;
    logic [7:0] wb_dat_i;
    logic [7:0] wb_dat_o;
    logic       wb_ack_o;

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
        input  wb_dat_o, wb_ack_o
    );

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
        output wb_dat_o, wb_ack_o
    );
endinterface

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - single-clock first-word-fall-through FIFO, power-of-two depth
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; only entries behind wr_ptr are ever read.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/wb_uart8.sv
// rtl/wb_uart8.sv - Wishbone byte-register UART (8N1) with TX FIFO and RX holding register
module wb_uart8
    import femto_uart_pkg::*;
#(
    parameter int CLK_DIV  = 208,
    parameter int TX_DEPTH = 8
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_i,
    wb_uart8_if.slave  wb,
    output logic       uart_tx,
    input  logic       uart_rx,
    output logic       irq_o
);

    localparam int             CW        = $clog2(CLK_DIV);
    localparam int             FAW       = $clog2(TX_DEPTH);
    localparam logic [CW-1:0]  DIV_LAST  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0]  HALF_LAST = CW'(CLK_DIV / 2 - 1);

    logic       req, data_rd, status_rd, data_wr, ctrl_wr;
    logic [1:0] adr;
    logic [5:0] unused_adr;
    logic [7:0] status, rd_mux;
    logic [1:0] ctrl;

    logic       fifo_full, fifo_empty;
    logic [7:0] fifo_rd_data;
    logic [FAW:0] unused_fifo_count;

    logic       rx_valid, rx_overrun, frame_err;
    logic [7:0] rx_data;
    logic       tx_busy, tx_empty;

    assign adr        = wb.wb_adr_i[1:0];
    assign unused_adr = wb.wb_adr_i[7:2];
    assign req        = wb.wb_cyc_i & wb.wb_stb_i & ~wb.wb_ack_o;
    assign data_rd    = req & ~wb.wb_we_i & (adr == REG_DATA);
    assign status_rd  = req & ~wb.wb_we_i & (adr == REG_STATUS);
    assign data_wr    = req &  wb.wb_we_i & (adr == REG_DATA);
    assign ctrl_wr    = req &  wb.wb_we_i & (adr == REG_CTRL);

    always_comb begin
        status                = '0;
        status[ST_TX_FULL]    = fifo_full;
        status[ST_TX_EMPTY]   = tx_empty;
        status[ST_RX_VALID]   = rx_valid;
        status[ST_RX_OVERRUN] = rx_overrun;
        status[ST_TX_BUSY]    = tx_busy;
        status[ST_FRAME_ERR]  = frame_err;
        case (adr)
            REG_DATA:   rd_mux = rx_data;
            REG_STATUS: rd_mux = status;
            REG_CTRL:   rd_mux = {6'b0, ctrl};
            default:    rd_mux = ID_VALUE;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wb.wb_ack_o <= 1'b0;
            wb.wb_dat_o <= '0;
            ctrl        <= '0;
        end else begin
            wb.wb_ack_o <= req;
            wb.wb_dat_o <= (req & ~wb.wb_we_i) ? rd_mux : 8'h00;
            if (ctrl_wr) ctrl <= wb.wb_dat_i[1:0];
        end
    end

    // ---------------- TX path ----------------
    tx_state_t     tx_state, tx_state_n;
    logic [CW-1:0] tx_cnt, tx_cnt_n;
    logic [2:0]    tx_bit, tx_bit_n;
    logic [7:0]    tx_shift, tx_shift_n;
    logic          tx_line, tx_line_n;
    logic          tx_pop, tx_expire;

    uart_sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk     (wb_clk_i),
        .rst     (wb_rst_i),
        .push    (data_wr),
        .wr_data (wb.wb_dat_i),
        .pop     (tx_pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (unused_fifo_count)
    );

    assign tx_busy   = (tx_state != TX_IDLE);
    assign tx_empty  = fifo_empty & ~tx_busy;
    assign tx_expire = (tx_cnt == DIV_LAST);
    assign uart_tx   = tx_line;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx_line  <= 1'b1;
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_bit   <= tx_bit_n;
            tx_shift <= tx_shift_n;
            tx_line  <= tx_line_n;
        end
    end

    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt;
        tx_bit_n   = tx_bit;
        tx_shift_n = tx_shift;
        tx_line_n  = tx_line;
        tx_pop     = 1'b0;
        if (tx_state != TX_IDLE) tx_cnt_n = tx_expire ? '0 : tx_cnt + CW'(1);
        case (tx_state)
            TX_IDLE: begin
                if (!fifo_empty) begin
                    tx_pop     = 1'b1;
                    tx_shift_n = fifo_rd_data;
                    tx_state_n = TX_START;
                    tx_line_n  = 1'b0;
                    tx_cnt_n   = '0;
                end
            end
            TX_START: begin
                if (tx_expire) begin
                    tx_state_n = TX_DATA;
                    tx_bit_n   = '0;
                    tx_line_n  = tx_shift[0];
                end
            end
            TX_DATA: begin
                if (tx_expire) begin
                    if (tx_bit == 3'd7) begin
                        tx_state_n = TX_STOP;
                        tx_line_n  = 1'b1;
                    end else begin
                        tx_bit_n   = tx_bit + 3'd1;
                        tx_shift_n = {1'b0, tx_shift[7:1]};
                        tx_line_n  = tx_shift[1];
                    end
                end
            end
            TX_STOP: begin
                // Chain straight into the next start bit so queued frames leave gap-free.
                if (tx_expire) begin
                    if (!fifo_empty) begin
                        tx_pop     = 1'b1;
                        tx_shift_n = fifo_rd_data;
                        tx_state_n = TX_START;
                        tx_line_n  = 1'b0;
                    end else begin
                        tx_state_n = TX_IDLE;
                    end
                end
            end
            default: tx_state_n = TX_IDLE;
        endcase
    end

    // ---------------- RX path ----------------
    rx_state_t     rx_state, rx_state_n;
    logic [CW-1:0] rx_cnt, rx_cnt_n;
    logic [2:0]    rx_bit, rx_bit_n;
    logic [7:0]    rx_shift, rx_shift_n;
    logic          rx_s1, rx_s2, rx_prev;
    logic          rx_good, rx_bad, rx_load, rx_ovr_set;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_prev  <= 1'b1;
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            rx_s1    <= uart_rx;
            rx_s2    <= rx_s1;
            rx_prev  <= rx_s2;
            rx_state <= rx_state_n;
            rx_cnt   <= rx_cnt_n;
            rx_bit   <= rx_bit_n;
            rx_shift <= rx_shift_n;
        end
    end

    always_comb begin
        rx_state_n = rx_state;
        rx_cnt_n   = rx_cnt;
        rx_bit_n   = rx_bit;
        rx_shift_n = rx_shift;
        rx_good    = 1'b0;
        rx_bad     = 1'b0;
        if (rx_state != RX_IDLE) rx_cnt_n = rx_cnt + CW'(1);
        case (rx_state)
            RX_IDLE: begin
                // Counter starts at 1 to absorb the cycle spent detecting the edge.
                if (rx_prev && !rx_s2) begin
                    rx_state_n = RX_START;
                    rx_cnt_n   = CW'(1);
                end
            end
            RX_START: begin
                if (rx_cnt == HALF_LAST) begin
                    rx_cnt_n   = '0;
                    rx_bit_n   = '0;
                    rx_state_n = rx_s2 ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_cnt == DIV_LAST) begin
                    rx_cnt_n   = '0;
                    rx_shift_n = {rx_s2, rx_shift[7:1]};
                    if (rx_bit == 3'd7) rx_state_n = RX_STOP;
                    else                rx_bit_n   = rx_bit + 3'd1;
                end
            end
            RX_STOP: begin
                if (rx_cnt == DIV_LAST) begin
                    rx_cnt_n   = '0;
                    rx_state_n = RX_IDLE;
                    rx_good    = rx_s2;
                    rx_bad     = ~rx_s2;
                end
            end
            default: rx_state_n = RX_IDLE;
        endcase
    end

    // A DATA read landing on the completion edge frees the holder, so the new byte wins.
    assign rx_load    = rx_good & (~rx_valid | data_rd);
    assign rx_ovr_set = rx_good & rx_valid & ~data_rd;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            rx_valid   <= 1'b0;
            rx_data    <= '0;
            rx_overrun <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            if (rx_load) begin
                rx_valid <= 1'b1;
                rx_data  <= rx_shift;
            end else if (data_rd) begin
                rx_valid <= 1'b0;
            end
            if (rx_ovr_set)     rx_overrun <= 1'b1;
            else if (status_rd) rx_overrun <= 1'b0;
            if (rx_bad)         frame_err  <= 1'b1;
            else if (status_rd) frame_err  <= 1'b0;
        end
    end

    assign irq_o = (ctrl[CTRL_RX_IRQ_EN] & rx_valid) | (ctrl[CTRL_TX_IRQ_EN] & tx_empty);

endmodule

// File: doc/wb_uart8.md
# wb_uart8

8-bit Wishbone classic responder providing one UART (8N1) with a TX FIFO and an RX holding register. It sits on the SoC's byte-wide Wishbone side, next to the on-chip hard peripherals, and answers the iomem-to-Wishbone bridge. Software reaches it through four byte registers. It raises a level interrupt for RX-ready and TX-drained.

## Interface
- `CLK_DIV`, default 208: clocks per UART bit (24 MHz / 115200). Minimum 4.
- `TX_DEPTH`, default 8: TX FIFO entries. Power of two, at least 2.
- `wb_clk_i` in 1: single clock for everything.
- `wb_rst_i` in 1: reset, asynchronous, active-high.
- `wb_cyc_i` in 1: bus cycle.
- `wb_stb_i` in 1: strobe.
- `wb_we_i` in 1: 1 = write.
- `wb_adr_i` in 8: byte register address. Only [1:0] are decoded; [7:2] are ignored.
- `wb_dat_i` in 8: write data.
- `wb_dat_o` out 8: read data. Valid only while `wb_ack_o`=1, otherwise 0.
- `wb_ack_o` out 1: single-cycle acknowledge.
- `uart_tx` out 1: serial out, idle high.
- `uart_rx` in 1: serial in, asynchronous.
- `irq_o` out 1: level interrupt.

## Operation
- Register map:
  - 0 DATA: write pushes the TX FIFO; read returns the RX byte and clears `rx_valid`.
  - 1 STATUS (read-only): b0 tx_full, b1 tx_empty (FIFO empty and shifter idle), b2 rx_valid, b3 rx_overrun, b4 tx_busy, b5 frame_err, b7:6 = 0.
  - 2 CTRL (R/W): b0 rx_irq_en, b1 tx_irq_en, others read 0.
  - 3 ID: reads 8'h5A; writes ignored.
- Bus access:
  - A request is `wb_cyc_i & wb_stb_i & !wb_ack_o`.
  - On a request edge: `wb_ack_o`<=1, `wb_dat_o`<=read data, and all side effects (push, pop, flag clear) happen exactly once.
  - Next edge: `wb_ack_o`<=0 and `wb_dat_o`<=0. There are no wait states, so back-to-back requests are acked every other cycle.
- Side effects:
  - Reading STATUS clears rx_overrun and frame_err. The value returned is the value before clearing.
  - A write to DATA while tx_full is still acked. The byte is dropped and the FIFO is unchanged.
- TX shifter, states IDLE → START → DATA → STOP → IDLE:
  - In IDLE with the FIFO non-empty, it pops one byte and enters START.
  - Bits go out LSB first.
  - Each state or bit lasts exactly CLK_DIV clocks from its own baud counter.
  - On STOP expiry it goes to START immediately if the FIFO is non-empty, otherwise to IDLE. Frames are therefore back-to-back with no idle gap.
- RX path, states IDLE → START → DATA → STOP:
  - `uart_rx` passes through a 2-flop synchronizer.
  - IDLE: a synchronized high→low transition enters START.
  - START: sample at CLK_DIV/2. If the line is high, it is a false start and the FSM returns to IDLE.
  - DATA: sample 8 bits every CLK_DIV, LSB first.
  - STOP: sample the stop bit after CLK_DIV.
    - Stop bit 0: set frame_err and discard the byte.
    - Stop bit 1 with rx_valid=0: load the holding register and set rx_valid.
    - Stop bit 1 with rx_valid=1: set rx_overrun and discard the new byte (the old byte is kept).
  - Return to IDLE right after the stop sample.
- Simultaneous DATA read and RX byte completion on the same edge: the read returns the old byte, the new byte is loaded, rx_valid stays 1, and no overrun is flagged.
- `irq_o` = (rx_irq_en & rx_valid) | (tx_irq_en & tx_empty). It is driven from registered state with no combinational path from bus inputs.

## Timing
- Reset values: `wb_ack_o`=0, `wb_dat_o`=0, `uart_tx`=1, `irq_o`=0. FIFO empty, CTRL=0, all flags 0, both FSMs IDLE, baud counters 0.
- Reset asserted mid-frame aborts immediately and `uart_tx` returns high asynchronously.
- Read latency is 1 clock: data appears with the ack, on the edge after the request is first sampled.
- TX start latency, with the FIFO empty and the shifter idle:
  - Push happens on ack edge E0.
  - Pop happens on E1, where `uart_tx` falls.
  - The frame lasts 10×CLK_DIV clocks.
- RX byte latency: rx_valid rises 2 (synchronizer) + CLK_DIV/2 + 9×CLK_DIV clocks after the falling start edge reaches the pin, ±1 clock.
- FIFO occupancy counts 0..TX_DEPTH. Pointers wrap modulo TX_DEPTH. A push and a pop on the same edge leave the count unchanged.

## Structure
- Shared package `femto_uart_pkg` holds:
  - the register offsets (DATA=0, STATUS=1, CTRL=2, ID=3) and ID value 8'h5A;
  - the STATUS and CTRL bit indices;
  - the TX and RX FSM state encodings.
- Sub-module `uart_sync_fifo` (parameters WIDTH, DEPTH):
  - signals push, pop, full, empty, count;
  - read data is first-word-fall-through.
- Everything else (bus decode, TX FSM, RX FSM) stays in `wb_uart8`.

## Test plan
All scenarios run with CLK_DIV=16.
- Reset, then read ID and STATUS → 8'h5A, then 8'h02 (tx_empty only); `uart_tx`=1, `irq_o`=0.
- Write DATA=8'hA5 → `uart_tx` low one clock after ack; serial sequence 0,1,0,1,0,0,1,0,1,1 with each bit 16 clocks.
- Write 9 bytes back-to-back with TX_DEPTH=8:
  - after 9 writes (one byte already popped into the shifter), STATUS reads 8'h11 (tx_full, tx_busy);
  - write a 10th byte, 8'hFF, while still full → it is dropped;
  - the first 9 bytes are transmitted gap-free, then tx_empty=1.
- Drive RX 8'h3C, then 8'hC3 without reading → after the first byte STATUS=8'h04; after the second, DATA still reads 8'h3C, STATUS=8'h0C, then a second STATUS read=8'h00.
- Drive a 4-clock low glitch on `uart_rx`, then a frame with a 0 stop bit → no rx_valid for the glitch; frame_err set; DATA not loaded.
- CTRL=8'h01, receive 8'h55 → `irq_o` rises with rx_valid; DATA read returns 8'h55 and `irq_o` falls the clock after ack.
